seq_array_multiplier: RTL
=========================

SEQ_ARRAY_MULTIPLIER -- requirements
Module: seq_array_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port acc_mode  input  1  1 = add the new result to the held product; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-009 SHALL have port busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; product valid in that cycle.
REQ-011 SHALL have port product  output  2*WIDTH  result register; holds its value between completions.
REQ-012 SHALL have port ovf  output  1  accumulate overflow flag; updated at each completion.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge:
  - latch a, b, signed_mode and acc_mode;
  - clear the partial sum and the bit counter;
  - move to RUN.
REQ-015 SHALL, in signed mode, convert the latched operands to magnitudes at latch time and record sign = a[MSB] XOR b[MSB].
REQ-016 SHALL, in RUN, process one multiplier bit per cycle, LSB first: if the bit is 1, add the multiplicand shifted by the bit index into the 2*WIDTH partial sum.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles, then move to DONE.
REQ-018 SHALL, on entry to DONE, compute the result:
  - raw = partial sum, negated (two's complement, 2*WIDTH bits) if signed and sign=1;
  - if acc_mode=0: product <= raw;
  - if acc_mode=1: product <= (product + raw) mod 2^(2*WIDTH).
REQ-019 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-020 SHALL give a latency from the start edge to the done-high edge of WIDTH+1 cycles; the next start is accepted on the cycle after done.
REQ-021 SHALL set ovf at each completion as follows:
  - acc_mode=0: ovf=0;
  - unsigned accumulate: ovf = carry out of the 2*WIDTH addition;
  - signed accumulate: ovf = signed overflow (operand signs equal, sum sign differs).
REQ-022 SHALL ignore start, and changes on a, b or the mode inputs, while busy=1; the latched values SHALL be unaffected.
REQ-023 SHALL hold product and ovf unchanged outside completion cycles.
REQ-024 SHALL produce results bit-exact with a*b for all operand pairs in both modes (signed: most negative times most negative is exact in 2*WIDTH bits).

Reset
REQ-025 SHALL, on rst_n=0 at any time (including mid-RUN), immediately force:
  - FSM = IDLE;
  - busy=0, done=0, product=0, ovf=0;
  - partial sum, counter and latched operands cleared.
REQ-026 SHALL discard any in-flight operation on reset, and SHALL NOT assert done for it after reset is released.

Verification (WIDTH=4)
REQ-027 SHALL cover unsigned: a=15, b=15, start -> busy for 5 cycles, done on cycle 5, product=0xE1, ovf=0.
REQ-028 SHALL cover signed: a=0xD (-3), b=0x5 -> product=0xF1 (-15); also a=0x8, b=0x8 -> product=0x40.
REQ-029 SHALL cover accumulate: product=0xE1, then unsigned acc_mode=1, a=15, b=15 -> product=0xC2, ovf=1.
REQ-030 SHALL cover start held high and a/b toggled during RUN -> single done; result of the originally latched operands; new op starts only after return to IDLE.
REQ-031 SHALL cover rst_n pulsed low on RUN cycle 2 -> outputs 0 immediately; no done pulse; a following op of 3*4 gives product=0x0C.
REQ-032 SHALL cover randomised a, b, signed_mode and acc_mode with WIDTH=4 and WIDTH=8 against a reference model: zero mismatches.

Source files
------------

// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add multiplier with optional signed operands and
// accumulate-into-product mode. One multiplier bit is consumed per cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a multiply (accepted only in IDLE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   acc_mode     1 = add new result to held product
//   a, b         multiplicand / multiplier (WIDTH bits)
//   busy         high while RUN or DONE
//   done         one-cycle pulse, product valid in that cycle
//   product      2*WIDTH result register, held between completions
//   ovf          accumulate overflow flag, updated at each completion
module seq_array_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 acc_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   mcand_sh;   // multiplicand magnitude, shifted left each RUN cycle
    logic [WIDTH-1:0] mplier_sh; // multiplier magnitude, shifted right each RUN cycle
    logic [PW-1:0]   psum;
    logic [CW-1:0]   cnt;
    logic            neg_l;
    logic            sgn_l;
    logic            acc_l;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    psum_next;
    logic [PW-1:0]    raw;
    logic [PW:0]      sum_ext;
    logic [PW-1:0]    product_next;
    logic             ovf_next;
    logic             last;

    always_comb begin
        // Magnitudes fit in WIDTH bits as unsigned, including the most negative value.
        a_mag        = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag        = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        addend       = mplier_sh[0] ? mcand_sh : '0;
        psum_next    = psum + addend;
        raw          = neg_l ? (~psum_next + PW'(1)) : psum_next;
        sum_ext      = {1'b0, product} + {1'b0, raw};
        last         = (cnt == CW'(WIDTH - 1));
        product_next = raw;
        ovf_next     = 1'b0;
        if (acc_l) begin
            product_next = sum_ext[PW-1:0];
            if (sgn_l)
                ovf_next = (product[PW-1] == raw[PW-1]) && (sum_ext[PW-1] != product[PW-1]);
            else
                ovf_next = sum_ext[PW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            psum      <= '0;
            cnt       <= '0;
            neg_l     <= 1'b0;
            sgn_l     <= 1'b0;
            acc_l     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_sh  <= PW'(a_mag);
                        mplier_sh <= b_mag;
                        neg_l     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_l     <= signed_mode;
                        acc_l     <= acc_mode;
                        psum      <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    psum      <= psum_next;
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                    cnt       <= cnt + CW'(1);
                    // Result is formed from the final partial sum on the edge into DONE.
                    if (last) begin
                        product <= product_next;
                        ovf     <= ovf_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
